// File: rtl/mdio_pkg.sv
// Shared MDIO management-frame definitions: frame codes, FSM encodings and
// header field positions used by both the station master and the PHY peripheral.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST_CODE = 2'b01;
  localparam logic [1:0] MDIO_OP_WR   = 2'b01;
  localparam logic [1:0] MDIO_OP_RD   = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_SKIP   = 3'd4;

  // Positions inside the 16-bit header {ST, OP, PHYADDR, REGADDR, TA}
  localparam int unsigned HDR_ST_MSB  = 15;
  localparam int unsigned HDR_ST_W    = 2;
  localparam int unsigned HDR_OP_MSB  = 13;
  localparam int unsigned HDR_OP_W    = 2;
  localparam int unsigned HDR_PHY_MSB = 11;
  localparam int unsigned HDR_PHY_W   = 5;
  localparam int unsigned HDR_REG_MSB = 6;
  localparam int unsigned HDR_REG_W   = 5;

  localparam logic [5:0] CNT_HDR_DONE   = 6'd16;
  localparam logic [5:0] CNT_FRAME_DONE = 6'd32;

endpackage

// File: rtl/mdio_edge_det.sv
// Registers the master's mdc in the system clock domain and flags its edges.
module mdio_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdc_q <= 1'b0;
    end else begin
      mdc_q <= mdc;
    end
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO management slave: deserialises 32-bit frames sampled on mdc
// rising edges, strobes register writes and serialises read data on falls.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'h01,
  parameter logic [1:0] ST_CODE  = MDIO_ST_CODE,
  parameter logic [1:0] OP_WR    = MDIO_OP_WR,
  parameter logic [1:0] OP_RD    = MDIO_OP_RD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  input  logic [15:0] rd_data,
  output logic        mdio_in,
  output logic [4:0]  addr,
  output logic        addr_vld,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        mdio_done
);

  logic        rise;
  logic        fall;
  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [15:0] shift;

  logic [15:0] shift_n;
  logic [5:0]  cnt_n;
  logic        hdr_ok;
  logic        hdr_wr;
  logic        hdr_rd;
  logic [4:0]  hdr_reg;

  mdio_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .mdc  (mdc),
    .rise (rise),
    .fall (fall)
  );

  // Header decode looks at the shift value including the bit sampled this cycle
  always_comb begin
    shift_n = {shift[14:0], mdio_out};
    cnt_n   = cnt + 6'd1;
    hdr_ok  = (shift_n[HDR_ST_MSB -: HDR_ST_W] == ST_CODE) &&
              (shift_n[HDR_PHY_MSB -: HDR_PHY_W] == PHY_ADDR);
    hdr_wr  = shift_n[HDR_OP_MSB -: HDR_OP_W] == OP_WR;
    hdr_rd  = shift_n[HDR_OP_MSB -: HDR_OP_W] == OP_RD;
    hdr_reg = shift_n[HDR_REG_MSB -: HDR_REG_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift     <= '0;
      mdio_in   <= 1'b0;
      addr      <= '0;
      addr_vld  <= 1'b0;
      wr_data   <= '0;
      wr_stb    <= 1'b0;
      mdio_done <= 1'b0;
    end else begin
      addr_vld  <= 1'b0;
      wr_stb    <= 1'b0;
      mdio_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise && mdio_oe) begin
            shift <= shift_n;
            cnt   <= 6'd1;
            state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (rise) begin
            if (!mdio_oe) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              shift <= shift_n;
              cnt   <= cnt_n;
              if (cnt_n == CNT_HDR_DONE) begin
                if (hdr_ok && hdr_wr) begin
                  addr  <= hdr_reg;
                  state <= S_WRITE;
                end else if (hdr_ok && hdr_rd) begin
                  addr     <= hdr_reg;
                  addr_vld <= 1'b1;
                  state    <= S_READ;
                end else begin
                  state <= S_SKIP;
                end
              end
            end
          end
        end
        S_WRITE: begin
          if (rise) begin
            if (!mdio_oe) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              shift <= shift_n;
              cnt   <= cnt_n;
              if (cnt_n == CNT_FRAME_DONE) begin
                wr_data   <= shift_n;
                wr_stb    <= 1'b1;
                mdio_done <= 1'b1;
                cnt       <= '0;
                state     <= S_IDLE;
              end
            end
          end
        end
        S_READ: begin
          // Data bit j = cnt-16 goes out on the fall so it is settled before the master samples
          if (rise) begin
            cnt <= cnt_n;
            if (cnt_n == CNT_FRAME_DONE) begin
              mdio_done <= 1'b1;
              mdio_in   <= 1'b0;
              cnt       <= '0;
              state     <= S_IDLE;
            end
          end else if (fall) begin
            mdio_in <= rd_data[4'd15 - cnt[3:0]];
          end
        end
        S_SKIP: begin
          if (rise) begin
            cnt <= cnt_n;
            if (cnt_n == CNT_FRAME_DONE) begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Self-checking bench for mdio_peripheral: a bench-side station master drives
// frames and a frame-level model predicts strobes, latched fields and read bits.
module tb_mdio_peripheral;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_out = 1'b0;
  logic        mdio_oe = 1'b0;
  logic [15:0] rd_data = '0;
  logic        mdio_in;
  logic [4:0]  addr;
  logic        addr_vld;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        mdio_done;

  int checks = 0;
  int errors = 0;

  int n_stb = 0;
  int n_done = 0;
  int n_vld = 0;
  int n_split = 0;
  logic [4:0] vld_addr = '0;

  logic [4:0]  exp_addr = '0;
  logic [15:0] exp_wr_data = '0;

  always #5 clk = ~clk;

  mdio_peripheral #(
    .PHY_ADDR (5'h01),
    .ST_CODE  (2'b01),
    .OP_WR    (2'b01),
    .OP_RD    (2'b10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .rd_data   (rd_data),
    .mdio_in   (mdio_in),
    .addr      (addr),
    .addr_vld  (addr_vld),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .mdio_done (mdio_done)
  );

  always @(negedge clk) begin
    if (wr_stb) n_stb++;
    if (mdio_done) n_done++;
    if (addr_vld) begin
      n_vld++;
      vld_addr = addr;
    end
    if (wr_stb && !mdio_done) n_split++;
  end

  // One complete frame from the master; abort_at >= 0 drops mdio_oe from that bit on
  task automatic run_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] data, input logic [15:0] rdd,
                           input int abort_at, input string tag);
    logic [31:0] frame;
    logic [31:0] obs_in;
    logic [31:0] exp_in;
    logic        end_stb;
    logic        end_done;
    bit          matched, is_wr, is_rd, hdr_ok, completes;
    int          s_stb, s_done, s_vld, s_split;
    int          e_stb, e_done, e_vld;

    matched   = (st == 2'b01) && (phy == 5'h01) && (op == 2'b01 || op == 2'b10);
    is_wr     = matched && (op == 2'b01);
    is_rd     = matched && (op == 2'b10);
    hdr_ok    = (abort_at < 0) || (abort_at >= 16);
    completes = hdr_ok && (is_rd || (is_wr && abort_at < 0));
    e_stb     = (completes && is_wr) ? 1 : 0;
    e_done    = completes ? 1 : 0;
    e_vld     = (is_rd && hdr_ok) ? 1 : 0;

    frame   = {st, op, phy, ra, 2'b10, data};
    rd_data = rdd;
    s_stb = n_stb; s_done = n_done; s_vld = n_vld; s_split = n_split;
    obs_in   = '0;
    end_stb  = 1'b0;
    end_done = 1'b0;

    for (int k = 0; k < 32; k++) begin
      mdc      = 1'b0;
      mdio_out = frame[31-k];
      mdio_oe  = (k < 16 || op != 2'b10) && !(abort_at >= 0 && k >= abort_at);
      repeat (H) @(negedge clk);
      obs_in[31-k] = mdio_in;
      mdc = 1'b1;
      if (k == 31) begin
        @(negedge clk);
        end_stb  = wr_stb;
        end_done = mdio_done;
        repeat (H-1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    mdio_oe = 1'b0;

    if (matched && hdr_ok) exp_addr = ra;
    if (completes && is_wr) exp_wr_data = data;
    exp_in = (is_rd && hdr_ok) ? {16'h0000, rdd} : 32'h0;

    checks++;
    if (end_stb !== e_stb[0]) begin
      errors++;
      $display("FAIL %s wr_stb_after_last_rise: got %0b expected %0b", tag, end_stb, e_stb[0]);
    end
    checks++;
    if (end_done !== e_done[0]) begin
      errors++;
      $display("FAIL %s mdio_done_after_last_rise: got %0b expected %0b", tag, end_done, e_done[0]);
    end
    checks++;
    if (n_stb - s_stb !== e_stb) begin
      errors++;
      $display("FAIL %s wr_stb_count: got %0d expected %0d", tag, n_stb - s_stb, e_stb);
    end
    checks++;
    if (n_done - s_done !== e_done) begin
      errors++;
      $display("FAIL %s mdio_done_count: got %0d expected %0d", tag, n_done - s_done, e_done);
    end
    checks++;
    if (n_vld - s_vld !== e_vld) begin
      errors++;
      $display("FAIL %s addr_vld_count: got %0d expected %0d", tag, n_vld - s_vld, e_vld);
    end
    if (e_vld == 1) begin
      checks++;
      if (vld_addr !== ra) begin
        errors++;
        $display("FAIL %s addr_at_vld: got %h expected %h", tag, vld_addr, ra);
      end
    end
    checks++;
    if (n_split - s_split !== 0) begin
      errors++;
      $display("FAIL %s stb_without_done: got %0d expected 0", tag, n_split - s_split);
    end
    checks++;
    if (addr !== exp_addr) begin
      errors++;
      $display("FAIL %s addr: got %h expected %h", tag, addr, exp_addr);
    end
    checks++;
    if (wr_data !== exp_wr_data) begin
      errors++;
      $display("FAIL %s wr_data: got %h expected %h", tag, wr_data, exp_wr_data);
    end
    checks++;
    if (obs_in !== exp_in) begin
      errors++;
      $display("FAIL %s mdio_in_bits: got %h expected %h", tag, obs_in, exp_in);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mdio_in, addr, addr_vld, wr_data, wr_stb, mdio_done} !== 25'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {mdio_in, addr, addr_vld, wr_data, wr_stb, mdio_done});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    run_frame(2'b01, 2'b01, 5'h01, 5'h0A, 16'hBEEF, 16'h0000, -1, "write_beef");
  endtask

  task automatic test_read;
    run_frame(2'b01, 2'b10, 5'h01, 5'h03, 16'h0000, 16'hA5C3, -1, "read_a5c3");
  endtask

  task automatic test_phy_mismatch;
    run_frame(2'b01, 2'b01, 5'h07, 5'h1F, 16'h1111, 16'h0000, -1, "phy_mismatch_wr");
    run_frame(2'b01, 2'b10, 5'h07, 5'h1E, 16'h0000, 16'hFFFF, -1, "phy_mismatch_rd");
    run_frame(2'b01, 2'b01, 5'h01, 5'h05, 16'h2222, 16'h0000, -1, "after_mismatch");
  endtask

  task automatic test_skip;
    run_frame(2'b00, 2'b01, 5'h01, 5'h06, 16'h3333, 16'h0000, -1, "skip_st00");
    run_frame(2'b01, 2'b11, 5'h01, 5'h07, 16'h4444, 16'h0000, -1, "skip_op11");
    run_frame(2'b01, 2'b00, 5'h01, 5'h08, 16'h5555, 16'h0000, -1, "skip_op00");
  endtask

  task automatic test_oe_abort;
    run_frame(2'b01, 2'b01, 5'h01, 5'h09, 16'h6666, 16'h0000, 8, "abort_header");
    run_frame(2'b01, 2'b01, 5'h01, 5'h0B, 16'h7777, 16'h0000, 24, "abort_write_data");
    run_frame(2'b01, 2'b01, 5'h01, 5'h0C, 16'h8888, 16'h0000, -1, "after_abort");
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] frame;
    int s_stb, s_done;
    frame  = {2'b01, 2'b01, 5'h01, 5'h0D, 2'b10, 16'h5A5A};
    s_stb  = n_stb;
    s_done = n_done;
    for (int k = 0; k < 20; k++) begin
      mdc = 1'b0; mdio_out = frame[31-k]; mdio_oe = 1'b1;
      repeat (H) @(negedge clk);
      mdc = 1'b1;
      repeat (H) @(negedge clk);
    end
    checks++;
    if (addr !== 5'h0D) begin
      errors++;
      $display("FAIL midreset_addr_before: got %h expected 0d", addr);
    end
    mdc = 1'b0; mdio_out = frame[11];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({mdio_in, addr, addr_vld, wr_data, wr_stb, mdio_done} !== 25'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {mdio_in, addr, addr_vld, wr_data, wr_stb, mdio_done});
    end
    repeat (3) @(negedge clk);
    mdio_oe = 1'b0;
    rst = 1'b1;
    repeat (H) @(negedge clk);
    checks++;
    if ((n_stb - s_stb) + (n_done - s_done) !== 0) begin
      errors++;
      $display("FAIL midreset_no_strobes: got %0d expected 0", (n_stb - s_stb) + (n_done - s_done));
    end
    exp_addr    = '0;
    exp_wr_data = '0;
    run_frame(2'b01, 2'b01, 5'h01, 5'h11, 16'h1234, 16'h0000, -1, "after_midreset");
  endtask

  task automatic test_back_to_back;
    int s_done;
    s_done = n_done;
    run_frame(2'b01, 2'b01, 5'h01, 5'h12, 16'h0001, 16'h0000, -1, "b2b_write");
    run_frame(2'b01, 2'b10, 5'h01, 5'h13, 16'h0000, 16'hFFFF, -1, "b2b_read");
    checks++;
    if (n_done - s_done !== 2) begin
      errors++;
      $display("FAIL b2b_done_total: got %0d expected 2", n_done - s_done);
    end
  endtask

  task automatic test_random;
    logic [1:0]  st, op;
    logic [4:0]  phy, ra;
    logic [15:0] data, rdd;
    int          abort_at;
    for (int i = 0; i < 40; i++) begin
      st       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
      op       = 2'($urandom);
      phy      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'h01;
      ra       = 5'($urandom);
      data     = 16'($urandom);
      rdd      = 16'($urandom);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : -1;
      run_frame(st, op, phy, ra, data, rdd, abort_at, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_phy_mismatch;
    test_skip;
    test_oe_abort;
    test_reset_mid_frame;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_peripheral.md
Name: mdio_peripheral

Overview:
- PHY-side MDIO management slave. It sits directly downstream of the station-management master on the same mdc/mdio link.
- Consumes the master's mdc, mdio_out and mdio_oe, and deserialises each 32-bit management frame {ST, OP, PHYADDR, REGADDR, TA, DATA}.
- Write frames: issues a register-file write strobe.
- Read frames: serialises register-file data back onto mdio_in during the data phase.
- Entirely synchronous to the system clk; mdc is treated as a data signal and edge-detected.

Parameters:
- PHY_ADDR, 5'h01, PHY address this peripheral answers to; frames addressed elsewhere are ignored.
- ST_CODE, 2'b01, required start-of-frame code.
- OP_WR, 2'b01, write opcode.
- OP_RD, 2'b10, read opcode.

Ports:
- clk  in  1  system clock; the same clock that generates mdc in the master.
- rst  in  1  asynchronous active-low reset.
- mdc  in  1  management clock from the master.
- mdio_out  in  1  serial data from the master.
- mdio_oe  in  1  master output enable; 1 = master driving.
- rd_data  in  16  register-file read data for ADDR; must be valid from the addr_vld pulse until end of frame.
- mdio_in  out  1  serial read data to the master.
- addr  out  5  REGADDR of the current or last frame.
- addr_vld  out  1  one-clk pulse when addr is valid for a matched read frame.
- wr_data  out  16  write data of the last completed write frame.
- wr_stb  out  1  one-clk write strobe.
- mdio_done  out  1  one-clk pulse at the end of every matched, completed frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0.
  - mdc_q=0, mdio_in=0, addr=0, addr_vld=0, wr_data=0, wr_stb=0, mdio_done=0.
- Edge detection: mdc_q registers mdc.
  - rise = mdc & !mdc_q; fall = !mdc & mdc_q.
  - All sampling happens in the clk cycle where rise=1.
- Bit counter: 6-bit, counts sampled bits 0..31; bit k = frame bit 31-k (MSB first).
- States:
  - IDLE: on rise with mdio_oe=1, shift in bit 0, cnt=1, go HEADER.
  - HEADER: shift mdio_out on each rise. At the rise that completes bit 15 (cnt becomes 16), decode shift[15:0]:
    - ST!=ST_CODE, or PHYADDR!=PHY_ADDR, or OP not in {OP_WR, OP_RD} -> SKIP.
    - OP_WR -> WRITE; addr <= REGADDR.
    - OP_RD -> READ; addr <= REGADDR, addr_vld pulses 1 clk.
    - If mdio_oe=0 at any rise in HEADER -> IDLE (abort, no outputs).
  - WRITE: shift 16 data bits. On the rise completing bit 31:
    - wr_data <= shift[15:0] in the same cycle; wr_stb=1 and mdio_done=1 in the following cycle.
    - Then -> IDLE.
    - If mdio_oe=0 at a rise -> IDLE with no wr_stb.
  - READ: on each fall, drive mdio_in = rd_data[15-j], where j = cnt-16.
    - The first bit is driven on the first fall after entering READ, so it is stable before the next rise.
    - mdio_oe is ignored in READ; the master has released the line.
    - On the rise where cnt reaches 32: mdio_done=1 next cycle, mdio_in <= 0, -> IDLE.
  - SKIP: count rises until cnt=32, then -> IDLE. No outputs change; mdio_in stays 0.
- Frame length: exactly 32 sampled bits. The turnaround bits are sampled but their value is not checked.
- Boundary and simultaneous events:
  - wr_stb and mdio_done assert together.
  - A new frame may start on the rise immediately after the IDLE return; back-to-back frames need no gap.
  - mdio_in = 0 outside READ.
  - wr_data and addr hold until overwritten.
  - Reset mid-frame returns to IDLE immediately, with no strobes.
- Latency: wr_stb and mdio_done occur 1 clk after the 32nd rise.

Decomposition:
- Package mdio_pkg holds:
  - ST/OP code constants;
  - state encoding (IDLE, HEADER, WRITE, READ, SKIP);
  - frame field bit positions.
- Both master and peripheral use mdio_pkg.
- One sub-module, mdio_edge_det: mdc register plus rise/fall outputs.

Test Plan:
- Write frame ST=01 OP=01 PHY=5'h01 REG=5'h0A DATA=16'hBEEF -> one wr_stb with addr=5'h0A, wr_data=16'hBEEF; mdio_done in the same cycle; mdio_in=0 throughout.
- Read frame REG=5'h03 with rd_data=16'hA5C3 -> addr_vld pulse with addr=5'h03; mdio_in sampled at rises 16..31 gives 1010_0101_1100_0011; mdio_done once.
- PHY=5'h07 write (mismatch) -> no wr_stb, no mdio_done; wr_data and addr keep their prior values; the next valid frame is accepted.
- ST=2'b00 or OP=2'b11 -> SKIP; no outputs for 32 bits; then IDLE.
- rst pulsed low at bit 20 of a write -> all outputs 0 immediately, no wr_stb. A subsequent full write of 16'h1234 succeeds.
- Back-to-back write 16'h0001 then read rd_data=16'hFFFF with no idle gap -> one wr_stb, then a correct read; two mdio_done pulses.
